// File: rtl/snn_pkg.sv
// snn_pkg: default field widths, word layouts and the dispatcher state
// encoding shared by the spike pipeline.
package snn_pkg;
  localparam int DEF_NID_W      = 16;
  localparam int DEF_TS_W       = 16;
  localparam int DEF_SPIKE_W    = DEF_TS_W + DEF_NID_W;
  localparam int DEF_SYN_ADDR_W = 16;
  localparam int DEF_FANOUT_W   = 8;
  localparam int DEF_WEIGHT_W   = 8;
  // spike word {ts, src}; pointer word {count, base}; synapse word {weight, target}
  localparam int SPIKE_SRC_LSB  = 0;
  localparam int SPIKE_TS_LSB   = DEF_NID_W;
  localparam int PTR_BASE_LSB   = 0;
  localparam int PTR_COUNT_LSB  = DEF_SYN_ADDR_W;
  localparam int SYN_TGT_LSB    = 0;
  localparam int SYN_WEIGHT_LSB = DEF_NID_W;
  typedef enum logic [2:0] {IDLE, LOOKUP, FETCH, WAITD, ISSUE} disp_state_t;
endpackage

// File: rtl/spike_dispatch_fsm.sv
// spike_dispatch_fsm: dispatcher state register, next-state logic and
// last-synapse compare.
module spike_dispatch_fsm
  import snn_pkg::*;
#(
  parameter int FANOUT_W = DEF_FANOUT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic [FANOUT_W-1:0] lookup_count,
  input  logic [FANOUT_W-1:0] idx,
  input  logic [FANOUT_W-1:0] count,
  input  logic                handshake,
  output disp_state_t         state
);
  disp_state_t next;
  logic        last;
  // idx < count <= 2^FANOUT_W-1 in ISSUE, so idx+1 cannot wrap
  assign last = (idx + FANOUT_W'(1)) == count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = fifo_empty ? IDLE : LOOKUP;
      LOOKUP:  next = (lookup_count == '0) ? IDLE : FETCH;
      FETCH:   next = WAITD;
      WAITD:   next = ISSUE;
      ISSUE:   next = !handshake ? ISSUE : last ? IDLE : FETCH;
      default: next = IDLE;
    endcase
  end
endmodule

// File: rtl/spike_dispatcher.sv
// spike_dispatcher: pops spikes, walks each source's fanout and issues one
// weighted event per synapse. SPIKE_DISPATCH_STATS_EN adds spike/event counters.
module spike_dispatcher
  import snn_pkg::*;
#(
  parameter int SPIKE_W    = DEF_SPIKE_W,
  parameter int NID_W      = DEF_NID_W,
  parameter int TS_W       = DEF_TS_W,
  parameter int SYN_ADDR_W = DEF_SYN_ADDR_W,
  parameter int FANOUT_W   = DEF_FANOUT_W,
  parameter int WEIGHT_W   = DEF_WEIGHT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SPIKE_W-1:0]           fifo_dout,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  output logic [NID_W-1:0]             ptr_addr,
  input  logic [FANOUT_W+SYN_ADDR_W-1:0] ptr_rdata,
  output logic [SYN_ADDR_W-1:0]        syn_addr,
  input  logic [WEIGHT_W+NID_W-1:0]    syn_rdata,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [NID_W-1:0]             ev_target,
  output logic [WEIGHT_W-1:0]          ev_weight,
  output logic [TS_W-1:0]              ev_ts,
  output logic                         busy
`ifdef SPIKE_DISPATCH_STATS_EN
  ,
  output logic [31:0]                  stat_spikes,
  output logic [31:0]                  stat_events
`endif
);
  disp_state_t           state;
  logic [NID_W-1:0]      src;
  logic [TS_W-1:0]       ts;
  logic [SYN_ADDR_W-1:0] base;
  logic [FANOUT_W-1:0]   count;
  logic [FANOUT_W-1:0]   idx;
  logic                  handshake;
  assign handshake  = ev_valid && ev_ready;
  assign fifo_rd_en = rst_n && state == IDLE && !fifo_empty;
  assign busy       = state != IDLE;
  assign ptr_addr   = src;
  spike_dispatch_fsm #(.FANOUT_W(FANOUT_W)) u_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .lookup_count (ptr_rdata[FANOUT_W+SYN_ADDR_W-1:SYN_ADDR_W]),
    .idx          (idx),
    .count        (count),
    .handshake    (handshake),
    .state        (state)
  );
  // table addresses are registered; both tables answer on the following cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src       <= '0;
      ts        <= '0;
      base      <= '0;
      count     <= '0;
      idx       <= '0;
      syn_addr  <= '0;
      ev_valid  <= 1'b0;
      ev_target <= '0;
      ev_weight <= '0;
      ev_ts     <= '0;
    end else begin
      case (state)
        IDLE:
          if (!fifo_empty) begin
            src <= fifo_dout[NID_W-1:0];
            ts  <= fifo_dout[SPIKE_W-1:NID_W];
          end
        LOOKUP: begin
          count <= ptr_rdata[FANOUT_W+SYN_ADDR_W-1:SYN_ADDR_W];
          base  <= ptr_rdata[SYN_ADDR_W-1:0];
          idx   <= '0;
        end
        FETCH: syn_addr <= base + SYN_ADDR_W'(idx);
        WAITD: begin
          ev_target <= syn_rdata[NID_W-1:0];
          ev_weight <= syn_rdata[WEIGHT_W+NID_W-1:NID_W];
          ev_ts     <= ts;
          ev_valid  <= 1'b1;
        end
        ISSUE:
          if (ev_ready) begin
            ev_valid <= 1'b0;
            idx      <= idx + FANOUT_W'(1);
          end
        default: ;
      endcase
    end
`ifdef SPIKE_DISPATCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stat_spikes <= '0;
      stat_events <= '0;
    end else begin
      stat_spikes <= stat_spikes + {31'd0, fifo_rd_en};
      stat_events <= stat_events + {31'd0, handshake};
    end
`endif
endmodule

// File: tb/tb_spike_dispatcher.sv
// tb_spike_dispatcher: directed and randomized checks of spike_dispatcher
// against a table-walk reference model.
module tb_spike_dispatcher;
  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  w;
    logic [15:0] tgt;
    logic [15:0] ts;
  } ev_t;
  logic        clk = 0, rst_n = 0;
  logic [31:0] fifo_dout;
  logic        fifo_empty, fifo_rd_en;
  logic [15:0] ptr_addr, syn_addr;
  logic [23:0] ptr_rdata, syn_rdata;
  logic        ev_valid, ev_ready = 0, busy;
  logic [15:0] ev_target, ev_ts;
  logic [7:0]  ev_weight;
`ifdef SPIKE_DISPATCH_STATS_EN
  logic [31:0] stat_spikes, stat_events;
`endif
  logic [23:0] ptr_mem [0:65535];
  logic [23:0] syn_mem [0:65535];
  logic [31:0] fifo_mem [0:255];
  logic [7:0]  rd_ptr = 0, wr_ptr = 0;
  int passed = 0, total = 0, cyc = 0;
  int n_pop = 0, n_ev = 0, n_busy = 0, n_valid = 0, n_hold = 0;
  logic        hold = 0;
  logic [39:0] held;
  ev_t         exp_q[$];
  int          pop_cyc[$], hs_cyc[$];
  logic [15:0] addr_log[$];
  logic [23:0] tw_log[$];
  logic [15:0] m_src, m_ts, m_base, m_a;
  logic [7:0]  m_cnt;
  ev_t         m_e;

  assign fifo_dout  = fifo_mem[rd_ptr];
  assign fifo_empty = rd_ptr == wr_ptr;
  assign ptr_rdata  = ptr_mem[ptr_addr];
  assign syn_rdata  = syn_mem[syn_addr];

  spike_dispatcher dut (
    .clk(clk), .rst_n(rst_n), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .ptr_addr(ptr_addr), .ptr_rdata(ptr_rdata),
    .syn_addr(syn_addr), .syn_rdata(syn_rdata), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_target(ev_target), .ev_weight(ev_weight),
    .ev_ts(ev_ts), .busy(busy)
`ifdef SPIKE_DISPATCH_STATS_EN
    , .stat_spikes(stat_spikes), .stat_events(stat_events)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 8'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] ts, input logic [15:0] src);
    fifo_mem[wr_ptr] = {ts, src};
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic wait_idle(input int lim);
    int k = 0;
    do begin
      tick();
      k++;
    end while ((busy || !fifo_empty || ev_valid) && k < lim);
    check("idle_timeout", 64'(k < lim), 64'd1);
  endtask

  // Reference: each pop expands into count events read from base+i, wrapping at 2^16
  always @(negedge clk) begin
    #2;
    if (!rst_n) hold = 0;
    else begin
      if (busy) n_busy++;
      if (ev_valid) n_valid++;
      if (hold) begin
        n_hold++;
        check("hold_valid", 64'(ev_valid), 64'd1);
        check("hold_fields", 64'({ev_target, ev_weight, ev_ts}), 64'(held));
      end
      hold = ev_valid && !ev_ready;
      held = {ev_target, ev_weight, ev_ts};
      if (fifo_rd_en) begin
        n_pop++;
        pop_cyc.push_back(cyc);
        m_src = fifo_dout[15:0];
        m_ts  = fifo_dout[31:16];
        {m_cnt, m_base} = ptr_mem[m_src];
        for (int i = 0; i < int'(m_cnt); i++) begin
          m_a = m_base + 16'(i);
          exp_q.push_back({m_a, syn_mem[m_a], m_ts});
        end
      end
      if (ev_valid && ev_ready) begin
        n_ev++;
        hs_cyc.push_back(cyc);
        addr_log.push_back(syn_addr);
        tw_log.push_back({ev_target, ev_weight});
        check("ev_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          m_e = exp_q.pop_front();
          check("ev_addr", 64'(syn_addr), 64'(m_e.addr));
          check("ev_fields", 64'({ev_weight, ev_target, ev_ts}), 64'({m_e.w, m_e.tgt, m_e.ts}));
        end
      end
    end
  end

  initial begin
    int b_pop, b_ev, b_busy, b_val, b_hold, b_a, b_p, b_h, k, pushes, exp_total;
    logic [15:0] s;
    for (int i = 0; i < 65536; i++) begin
      ptr_mem[i] = '0;
      syn_mem[i] = 24'($urandom);
    end
    for (int i = 32; i < 64; i++) ptr_mem[i] = {8'($urandom_range(0, 4)), 16'($urandom)};
    ptr_mem[5]  = {8'd3, 16'h0010};
    syn_mem[16] = {8'd4, 16'd7};
    syn_mem[17] = {8'hFE, 16'd9};
    syn_mem[18] = {8'd1, 16'd12};
    ptr_mem[2]  = {8'd0, 16'h0300};
    ptr_mem[9]  = {8'd3, 16'hFFFE};
    ptr_mem[20] = {8'd2, 16'h0100};
    ptr_mem[21] = {8'd1, 16'h0200};
    ev_ready = 1;
    repeat (3) tick();
    check("rst_ev_valid", 64'(ev_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ev_data", 64'({ev_target, ev_weight, ev_ts}), 64'd0);
    check("rst_addrs", 64'({ptr_addr, syn_addr}), 64'd0);
    push(16'h1234, 16'd5);
    #1;
    check("rd_en_in_reset", 64'(fifo_rd_en), 64'd0);
    // single spike: latency, values, one pop
    tick();
    rst_n = 1;
    #1;
    check("pop_strobe", 64'(fifo_rd_en), 64'd1);
    repeat (3) tick();
    check("valid_early", 64'(ev_valid), 64'd0);
    tick();
    check("valid_4th", 64'(ev_valid), 64'd1);
    check("first_ts", 64'(ev_ts), 64'h1234);
    check("first_addr", 64'(syn_addr), 64'h0010);
    wait_idle(50);
    check("t1_pops", 64'(n_pop), 64'd1);
    check("t1_events", 64'(n_ev), 64'd3);
    check("t1_ev0", 64'(tw_log[0]), 64'({16'd7, 8'd4}));
    check("t1_ev1", 64'(tw_log[1]), 64'({16'd9, 8'hFE}));
    check("t1_ev2", 64'(tw_log[2]), 64'({16'd12, 8'd1}));
    check("t1_lat", 64'(hs_cyc[0] - pop_cyc[0]), 64'd4);
    check("t1_rate", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
    // zero fanout
    b_pop = n_pop; b_ev = n_ev; b_busy = n_busy; b_val = n_valid;
    push(16'h0042, 16'd2);
    wait_idle(20);
    repeat (3) tick();
    check("t2_pops", 64'(n_pop - b_pop), 64'd1);
    check("t2_events", 64'(n_ev - b_ev), 64'd0);
    check("t2_valid", 64'(n_valid - b_val), 64'd0);
    check("t2_busy", 64'(n_busy - b_busy), 64'd1);
    // backpressure on the second event
    b_pop = n_pop; b_ev = n_ev; b_a = tw_log.size();
    push(16'h5555, 16'd5);
    k = 0;
    do begin
      tick();
      k++;
    end while (!(ev_valid && n_ev == b_ev + 1) && k < 40);
    check("bp_reach", 64'(k < 40), 64'd1);
    ev_ready = 0;
    b_hold = n_hold;
    repeat (5) tick();
    ev_ready = 1;
    check("bp_no_accept", 64'(n_ev - b_ev), 64'd1);
    wait_idle(50);
    check("bp_hold_cycles", 64'(n_hold - b_hold), 64'd5);
    check("bp_events", 64'(n_ev - b_ev), 64'd3);
    check("bp_pops", 64'(n_pop - b_pop), 64'd1);
    check("bp_order", 64'({tw_log[b_a], tw_log[b_a+1], tw_log[b_a+2]}),
          64'({16'd7, 8'd4, 16'd9, 8'hFE, 16'd12, 8'd1}));
    // synapse address wrap
    b_a = addr_log.size();
    push(16'h0777, 16'd9);
    wait_idle(50);
    check("wrap_a0", 64'(addr_log[b_a]), 64'hFFFE);
    check("wrap_a1", 64'(addr_log[b_a+1]), 64'hFFFF);
    check("wrap_a2", 64'(addr_log[b_a+2]), 64'h0000);
    // back-to-back spikes after a reset
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
`ifdef SPIKE_DISPATCH_STATS_EN
    check("stat_rst", 64'({stat_spikes, stat_events}), 64'd0);
`endif
    b_p = pop_cyc.size(); b_h = hs_cyc.size();
    push(16'h0001, 16'd20);
    push(16'h0002, 16'd21);
    wait_idle(50);
    check("b2b_pops", 64'(pop_cyc.size() - b_p), 64'd2);
    check("b2b_events", 64'(hs_cyc.size() - b_h), 64'd3);
    check("b2b_first_lat", 64'(hs_cyc[b_h] - pop_cyc[b_p]), 64'd4);
    check("b2b_second_pop", 64'(pop_cyc[b_p+1] - hs_cyc[b_h+1]), 64'd1);
`ifdef SPIKE_DISPATCH_STATS_EN
    check("stat_spikes", 64'(stat_spikes), 64'd2);
    check("stat_events", 64'(stat_events), 64'd3);
`endif
    // reset during ISSUE
    ev_ready = 0;
    b_ev = n_ev;
    push(16'h0999, 16'd5);
    k = 0;
    do begin
      tick();
      k++;
    end while (!ev_valid && k < 20);
    check("rst_reach", 64'(k < 20), 64'd1);
    rst_n = 0;
    #1;
    check("rst_mid_valid", 64'(ev_valid), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    exp_q.delete();
    tick();
    rst_n = 1;
    ev_ready = 1;
    push(16'h0AAA, 16'd21);
    wait_idle(30);
    check("rst_resume", 64'(n_ev - b_ev), 64'd1);
    check("rst_drained", 64'(exp_q.size()), 64'd0);
    // randomized traffic with random backpressure
    b_ev = n_ev; exp_total = 0; pushes = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      ev_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 5) == 0 && pushes < 40) begin
        s = 16'($urandom_range(32, 63));
        push(16'($urandom), s);
        exp_total += int'(ptr_mem[s][23:16]);
        pushes++;
      end
    end
    ev_ready = 1;
    wait_idle(3000);
    check("rand_events", 64'(n_ev - b_ev), 64'(exp_total));
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
